// File: rtl/hc_csr_bank.sv
// hc_csr_bank: parametrised MMIO CSR bank for HardCloud AFUs.
//
// Answers host MMIO reads and writes (flattened CCI-P c0/c2 fields) with the
// device feature header, the AFU UUID, control/scratch/status/DSM registers
// and NUM_BUFFERS buffer address/size pairs. It also generates a one-cycle
// start strobe and keeps a write-one-to-clear sticky done flag.
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   mmio_rd_valid/wr_valid     read / write request strobes
//   mmio_addr, mmio_tid        dword address and transaction ID
//   mmio_wdata                 64-bit write data
//   rsp_valid/rsp_tid/rsp_data read response, two cycles after the request
//   hc_control, start_pulse    control register and start strobe
//   busy, done_pulse, status_in core status inputs
//   hc_dsm_base                DSM cache-line address
//   buf_addr, buf_size         flattened per-buffer address / size
module hc_csr_bank #(
  parameter int             NUM_BUFFERS = 4,
  parameter logic [127:0]   AFU_ID      = 128'h0,
  parameter int             SIZE_W      = 32
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          mmio_rd_valid,
  input  logic                          mmio_wr_valid,
  input  logic [15:0]                   mmio_addr,
  input  logic [8:0]                    mmio_tid,
  input  logic [63:0]                   mmio_wdata,
  output logic                          rsp_valid,
  output logic [8:0]                    rsp_tid,
  output logic [63:0]                   rsp_data,
  output logic [31:0]                   hc_control,
  output logic                          start_pulse,
  input  logic                          busy,
  input  logic                          done_pulse,
  input  logic [31:0]                   status_in,
  output logic [57:0]                   hc_dsm_base,
  output logic [NUM_BUFFERS*58-1:0]     buf_addr,
  output logic [NUM_BUFFERS*SIZE_W-1:0] buf_size
);

  localparam logic [63:0] DFH    = 64'h1000_0000_1000_0000;
  localparam logic [7:0]  NB_IDX = 8'(NUM_BUFFERS);

  // Registered request stage
  logic        rdValid_q, wrValid_q, donePulse_q;
  logic [15:0] addr_q;
  logic [8:0]  tid_q;
  logic [63:0] wdata_q;

  // Architectural registers
  logic [63:0]                          scratch_q, scratch_d;
  logic [31:0]                          control_q, control_d;
  logic [57:0]                          dsm_q, dsm_d;
  logic [NUM_BUFFERS-1:0][57:0]         bufAddr_q, bufAddr_d;
  logic [NUM_BUFFERS-1:0][SIZE_W-1:0]   bufSize_q, bufSize_d;
  logic                                 done_q, done_d;
  logic                                 start_q, start_d;
  logic                                 rspValid_q, rspValid_d;
  logic [8:0]                           rspTid_q, rspTid_d;
  logic [63:0]                          rspData_q, rspData_d;

  // Address decode of the registered request
  logic       inRange, isBufSpace, bufHit, doneClr;
  logic [7:0] bufIdx;
  logic [63:0] rdData;

  assign inRange    = (addr_q[15:10] == 6'd0);
  assign isBufSpace = inRange && (addr_q[9:6] != 4'd0) && !addr_q[0];
  // Buffer i occupies dwords 0x40+4i (address) and 0x42+4i (size)
  assign bufIdx     = addr_q[9:2] - 8'h10;
  assign bufHit     = isBufSpace && (bufIdx < NB_IDX);

  // Input stage: all request fields and the done strobe are captured
  // together, so a done strobe and a STATUS clear issued in the same cycle
  // land on the same update edge, where the set takes priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdValid_q   <= 1'b0;
      wrValid_q   <= 1'b0;
      donePulse_q <= 1'b0;
      addr_q      <= '0;
      tid_q       <= '0;
      wdata_q     <= '0;
    end else begin
      rdValid_q   <= mmio_rd_valid;
      wrValid_q   <= mmio_wr_valid;
      donePulse_q <= done_pulse;
      addr_q      <= mmio_addr;
      tid_q       <= mmio_tid;
      wdata_q     <= mmio_wdata;
    end
  end

  // Read mux; odd dword addresses never match any entry and return zero
  always_comb begin
    rdData = '0;
    case (addr_q)
      16'h0000: rdData = DFH;
      16'h0002: rdData = AFU_ID[63:0];
      16'h0004: rdData = AFU_ID[127:64];
      16'h000A: rdData = scratch_q;
      16'h000C: rdData = {32'b0, control_q};
      16'h000E: rdData = {status_in, 30'b0, done_q, busy};
      16'h0010: rdData = {dsm_q, 6'b0};
      default:  rdData = '0;
    endcase
    if (bufHit) begin
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        if (bufIdx == 8'(i)) begin
          rdData = addr_q[1] ? 64'(bufSize_q[i]) : {bufAddr_q[i], 6'b0};
        end
      end
    end
  end

  // Next-state: register writes, start strobe, sticky done and response
  always_comb begin
    scratch_d = scratch_q;
    control_d = control_q;
    dsm_d     = dsm_q;
    bufAddr_d = bufAddr_q;
    bufSize_d = bufSize_q;
    start_d   = 1'b0;
    doneClr   = 1'b0;
    if (wrValid_q) begin
      case (addr_q)
        16'h000A: scratch_d = wdata_q;
        16'h000C: begin
          control_d = wdata_q[31:0];
          start_d   = wdata_q[0];
        end
        16'h000E: doneClr = wdata_q[1];
        16'h0010: dsm_d = wdata_q[63:6];
        default:  ;
      endcase
      if (bufHit) begin
        for (int i = 0; i < NUM_BUFFERS; i++) begin
          if (bufIdx == 8'(i)) begin
            if (addr_q[1]) bufSize_d[i] = wdata_q[SIZE_W-1:0];
            else           bufAddr_d[i] = wdata_q[63:6];
          end
        end
      end
    end
    done_d     = donePulse_q | (done_q & ~doneClr);
    rspValid_d = rdValid_q && inRange;
    rspTid_d   = rspValid_d ? tid_q  : '0;
    rspData_d  = rspValid_d ? rdData : '0;
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scratch_q  <= '0;
      control_q  <= '0;
      dsm_q      <= '0;
      bufAddr_q  <= '0;
      bufSize_q  <= '0;
      done_q     <= 1'b0;
      start_q    <= 1'b0;
      rspValid_q <= 1'b0;
      rspTid_q   <= '0;
      rspData_q  <= '0;
    end else begin
      scratch_q  <= scratch_d;
      control_q  <= control_d;
      dsm_q      <= dsm_d;
      bufAddr_q  <= bufAddr_d;
      bufSize_q  <= bufSize_d;
      done_q     <= done_d;
      start_q    <= start_d;
      rspValid_q <= rspValid_d;
      rspTid_q   <= rspTid_d;
      rspData_q  <= rspData_d;
    end
  end

  assign rsp_valid   = rspValid_q;
  assign rsp_tid     = rspTid_q;
  assign rsp_data    = rspData_q;
  assign hc_control  = control_q;
  assign start_pulse = start_q;
  assign hc_dsm_base = dsm_q;
  assign buf_addr    = bufAddr_q;
  assign buf_size    = bufSize_q;

endmodule
